// File: rtl/mm_result_regs.sv
// ---------------------------------------------------------------------------
// mm_result_regs
//
// Output-stage register bank of the matrix-multiplier datapath. Sits between
// the multiply/accumulate array and the result write-back path and holds two
// independent, individually enabled pipeline registers:
//
//   finaldata_reg      : captures the widened accumulator result, narrows it
//                        to DATA_WIDTH bits (saturating) and flags overflow.
//   partialproduct_reg : captures a 2*DATA_WIDTH-bit partial product and its
//                        carry, unmodified.
//
// Ports (mm_result_regs):
//   clk                 in   1              rising-edge clock
//   reset_n             in   1              synchronous reset, ACTIVE HIGH
//   en_FDReg            in   1              final-data load enable
//   fd_inData           in   2*DW+1         widened accumulator result
//   fd_outData          out  DW             registered, narrowed result
//   fd_resultIsInvalid  out  1              registered overflow flag
//   en_PPReg            in   1              partial-product load enable
//   pp_inData           in   2*DW           partial product
//   pp_cin              in   1              carry belonging to pp_inData
//   pp_outData          out  2*DW           registered partial product
//   pp_cout             out  1              registered carry
//
// All outputs come straight from flops; there is no input-to-output
// combinational path. Reset overrides both enables.
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// finaldata_reg
//
// Narrowing register for the accumulator result. Any set bit at or above
// position DATA_WIDTH means the value does not fit; the output then saturates
// to all ones and the invalid flag is raised. An in-range all-ones value is a
// legitimate result and leaves the flag clear.
//
// Ports:
//   clk        in   1           clock
//   srst       in   1           synchronous active-high reset
//   en_i       in   1           load enable
//   data_i     in   2*DW+1      widened input
//   data_o     out  DW          narrowed registered result
//   invalid_o  out  1           registered overflow flag
// ---------------------------------------------------------------------------
module finaldata_reg #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                    clk,
   input  logic                    srst,
   input  logic                    en_i,
   input  logic [2*DATA_WIDTH:0]   data_i,
   output logic [DATA_WIDTH-1:0]   data_o,
   output logic                    invalid_o
);

   localparam int IN_W = 2*DATA_WIDTH + 1;

   logic [IN_W-1:DATA_WIDTH] upper_bits;
   logic                     overflow;
   logic [DATA_WIDTH-1:0]    narrowed;

   logic [DATA_WIDTH-1:0]    data_q, data_d;
   logic                     invalid_q, invalid_d;

   assign upper_bits = data_i[IN_W-1:DATA_WIDTH];
   assign overflow   = |upper_bits;

   // Per-bit saturation: every result bit is forced high on overflow.
   generate
      for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_sat
         assign narrowed[gi] = data_i[gi] | overflow;
      end
   endgenerate

   always_comb begin
      data_d    = data_q;
      invalid_d = invalid_q;
      if (en_i) begin
         data_d    = narrowed;
         invalid_d = overflow;
      end
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         data_q    <= '0;
         invalid_q <= 1'b0;
      end else begin
         data_q    <= data_d;
         invalid_q <= invalid_d;
      end
   end

   assign data_o    = data_q;
   assign invalid_o = invalid_q;

endmodule

// ---------------------------------------------------------------------------
// partialproduct_reg
//
// Plain enabled register for a partial product and its carry. Data passes
// through untouched.
//
// Ports:
//   clk     in   1        clock
//   srst    in   1        synchronous active-high reset
//   en_i    in   1        load enable
//   data_i  in   2*DW     partial product
//   cin_i   in   1        carry in
//   data_o  out  2*DW     registered partial product
//   cout_o  out  1        registered carry
// ---------------------------------------------------------------------------
module partialproduct_reg #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                      clk,
   input  logic                      srst,
   input  logic                      en_i,
   input  logic [2*DATA_WIDTH-1:0]   data_i,
   input  logic                      cin_i,
   output logic [2*DATA_WIDTH-1:0]   data_o,
   output logic                      cout_o
);

   logic [2*DATA_WIDTH-1:0] data_q, data_d;
   logic                    carry_q, carry_d;

   always_comb begin
      data_d  = data_q;
      carry_d = carry_q;
      if (en_i) begin
         data_d  = data_i;
         carry_d = cin_i;
      end
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         data_q  <= '0;
         carry_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         carry_q <= carry_d;
      end
   end

   assign data_o = data_q;
   assign cout_o = carry_q;

endmodule

// ---------------------------------------------------------------------------
// mm_result_regs : wrapper joining the two registers. Note that reset_n is
// active HIGH despite its name.
// ---------------------------------------------------------------------------
module mm_result_regs #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      en_FDReg,
   input  logic [2*DATA_WIDTH:0]     fd_inData,
   output logic [DATA_WIDTH-1:0]     fd_outData,
   output logic                      fd_resultIsInvalid,
   input  logic                      en_PPReg,
   input  logic [2*DATA_WIDTH-1:0]   pp_inData,
   input  logic                      pp_cin,
   output logic [2*DATA_WIDTH-1:0]   pp_outData,
   output logic                      pp_cout
);

   logic srst;
   assign srst = reset_n;

   finaldata_reg #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_finaldata_reg (
      .clk       (clk),
      .srst      (srst),
      .en_i      (en_FDReg),
      .data_i    (fd_inData),
      .data_o    (fd_outData),
      .invalid_o (fd_resultIsInvalid)
   );

   partialproduct_reg #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_partialproduct_reg (
      .clk    (clk),
      .srst   (srst),
      .en_i   (en_PPReg),
      .data_i (pp_inData),
      .cin_i  (pp_cin),
      .data_o (pp_outData),
      .cout_o (pp_cout)
   );

endmodule

// File: tb/tb_mm_result_regs.sv
// ---------------------------------------------------------------------------
// tb_mm_result_regs : directed self-checking bench for mm_result_regs
// (DATA_WIDTH = 8). Inputs are driven 1 time unit after a rising edge and
// outputs are sampled at the same point after the following edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mm_result_regs;

   localparam int DW = 8;

   logic              clk;
   logic              reset_n;
   logic              en_FDReg;
   logic [2*DW:0]     fd_inData;
   logic [DW-1:0]     fd_outData;
   logic              fd_resultIsInvalid;
   logic              en_PPReg;
   logic [2*DW-1:0]   pp_inData;
   logic              pp_cin;
   logic [2*DW-1:0]   pp_outData;
   logic              pp_cout;

   int num_checks = 0;
   int num_errors = 0;

   mm_result_regs #(.DATA_WIDTH(DW)) dut (
      .clk                (clk),
      .reset_n            (reset_n),
      .en_FDReg           (en_FDReg),
      .fd_inData          (fd_inData),
      .fd_outData         (fd_outData),
      .fd_resultIsInvalid (fd_resultIsInvalid),
      .en_PPReg           (en_PPReg),
      .pp_inData          (pp_inData),
      .pp_cin             (pp_cin),
      .pp_outData         (pp_outData),
      .pp_cout            (pp_cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      num_checks++;
      if (obs !== exp) begin
         num_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, obs);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string tag, input logic [DW-1:0] fd, input logic inv,
                            input logic [2*DW-1:0] pp, input logic cout);
      check_val({tag, ".fd"},   {24'h0, fd_outData}, {24'h0, fd});
      check_val({tag, ".inv"},  {31'h0, fd_resultIsInvalid}, {31'h0, inv});
      check_val({tag, ".pp"},   {16'h0, pp_outData}, {16'h0, pp});
      check_val({tag, ".cout"}, {31'h0, pp_cout}, {31'h0, cout});
   endtask

   // PP stimulus table for the load sequence
   logic [15:0] pp_vec  [3] = '{16'h0000, 16'hFFFF, 16'hA5A5};
   logic        cin_vec [3] = '{1'b0, 1'b1, 1'b0};

   initial begin
      // 1. Reset with both enables active and nonzero inputs
      reset_n   = 1'b1;
      en_FDReg  = 1'b1;
      en_PPReg  = 1'b1;
      fd_inData = 17'h12C;
      pp_inData = 16'h1234;
      pp_cin    = 1'b1;
      tick();
      check_all("reset0", 8'h00, 1'b0, 16'h0000, 1'b0);
      tick();
      check_all("reset1", 8'h00, 1'b0, 16'h0000, 1'b0);

      // 2. FD valid loads; PP disabled
      reset_n   = 1'b0;
      en_PPReg  = 1'b0;
      fd_inData = 17'h0C8;
      tick();
      check_all("fd200", 8'hC8, 1'b0, 16'h0000, 1'b0);
      fd_inData = 17'h0FF;
      tick();
      check_all("fdFF", 8'hFF, 1'b0, 16'h0000, 1'b0);

      // 3. FD overflow and recovery
      fd_inData = 17'h12C;
      tick();
      check_all("fd300", 8'hFF, 1'b1, 16'h0000, 1'b0);
      fd_inData = 17'h1FFFF;
      tick();
      check_all("fd1FFFF", 8'hFF, 1'b1, 16'h0000, 1'b0);
      fd_inData = 17'h10000;
      tick();
      check_all("fdtop", 8'hFF, 1'b1, 16'h0000, 1'b0);
      fd_inData = 17'h010;
      tick();
      check_all("fd010", 8'h10, 1'b0, 16'h0000, 1'b0);

      // 4. Load both, then hold for 5 cycles with different inputs
      en_FDReg  = 1'b1;
      en_PPReg  = 1'b1;
      fd_inData = 17'h0C8;
      pp_inData = 16'hBEEF;
      pp_cin    = 1'b1;
      tick();
      check_all("load", 8'hC8, 1'b0, 16'hBEEF, 1'b1);
      en_FDReg  = 1'b0;
      en_PPReg  = 1'b0;
      fd_inData = 17'h12C;
      pp_inData = 16'h1234;
      pp_cin    = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check_all($sformatf("hold%0d", i), 8'hC8, 1'b0, 16'hBEEF, 1'b1);
      end

      // 5. PP load sequence, FD untouched; verify one-cycle latency
      en_PPReg  = 1'b1;
      fd_inData = 17'h1FFFF;
      for (int i = 0; i < 3; i++) begin
         pp_inData = pp_vec[i];
         pp_cin    = cin_vec[i];
         if (i == 0) begin
            // output still shows the old value before the capture edge
            check_val("pp_pre.pp", {16'h0, pp_outData}, 32'h0000BEEF);
         end
         tick();
         check_all($sformatf("pp%0d", i), 8'hC8, 1'b0, pp_vec[i], cin_vec[i]);
      end

      // 6. Reset mid-operation and reload after release
      en_FDReg  = 1'b1;
      en_PPReg  = 1'b1;
      fd_inData = 17'h055;
      pp_inData = 16'h1357;
      pp_cin    = 1'b1;
      tick();
      check_all("pre_rst", 8'h55, 1'b0, 16'h1357, 1'b1);
      reset_n   = 1'b1;
      fd_inData = 17'h0AA;
      pp_inData = 16'h2468;
      tick();
      check_all("mid_rst", 8'h00, 1'b0, 16'h0000, 1'b0);
      reset_n = 1'b0;
      tick();
      check_all("post_rst", 8'hAA, 1'b0, 16'h2468, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
      $finish;
   end

endmodule
